// File: rtl/serial_adder_unit.sv
// rtl/serial_adder_unit.sv - bit-serial add/subtract unit built around a 1-bit full adder
// Operands are consumed LSB first, one bit per clock; the carry flip-flop closes the loop between cycles.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_d;
  logic [WIDTH-1:0]  op_a, op_b, acc;
  logic [CW-1:0]     cnt;
  logic              carry;
  logic              fa_s, fa_co;
  logic              load, last_step;

  full_adder u_fa (
    .a  (op_a[0]),
    .b  (op_b[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // start is only honoured when no operation is in flight (IDLE or the DONE cycle)
  assign load      = start && (state != SHIFT);
  assign last_step = (state == SHIFT) && (cnt == LAST);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt == LAST) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Sum      <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d == SHIFT);
      done  <= last_step;
      if (load) begin
        op_a  <= A;
        op_b  <= sub ? ~B : B;
        carry <= sub;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        op_a  <= op_a >> 1;
        op_b  <= op_b >> 1;
        acc   <= {fa_s, acc[WIDTH-1:1]};
        carry <= fa_co;
        cnt   <= last_step ? '0 : cnt + CW'(1);
      end
      // on the MSB step carry still holds the carry into the MSB
      if (last_step) begin
        Sum      <= {fa_s, acc[WIDTH-1:1]};
        Cout     <= fa_co;
        Overflow <= carry ^ fa_co;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_unit.sv
// tb/tb_serial_adder_unit.sv - self-checking bench for serial_adder_unit (WIDTH=8)

module tb_serial_adder_unit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, sub;
  logic [W-1:0] A, B;
  logic         busy, done, Cout, Overflow;
  logic [W-1:0] Sum;

  int checks = 0;
  int errors = 0;

  serial_adder_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(A), .B(B),
    .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output int lat);
    @(negedge clk);
    A = a; B = b; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] m_sum, output logic m_cout, output logic m_ovf);
    int sa, sb, sr;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sr = s ? sa - sb : sa + sb;
    m_sum  = s ? W'(int'(a) - int'(b)) : W'(int'(a) + int'(b));
    m_cout = s ? (a >= b) : ((int'(a) + int'(b)) > 255);
    m_ovf  = (sr > 127) || (sr < -128);
  endtask

  initial begin
    vec_t          vecs[5];
    int            lat, ndone;
    logic [W-1:0]  ra, rb, m_sum;
    logic          rs, m_cout, m_ovf;

    vecs[0] = '{8'd100, 8'd27,  1'b0, 8'd127, 1'b0, 1'b0};
    vecs[1] = '{8'd200, 8'd100, 1'b0, 8'h2C,  1'b1, 1'b0};
    vecs[2] = '{8'h7F,  8'h01,  1'b0, 8'h80,  1'b0, 1'b1};
    vecs[3] = '{8'd5,   8'd7,   1'b1, 8'hFE,  1'b0, 1'b0};
    vecs[4] = '{8'h80,  8'h01,  1'b1, 8'h7F,  1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", Sum, 0);
    chk("reset_cout", Cout, 0);
    chk("reset_ovf", Overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // busy must rise right after the start edge
    @(negedge clk);
    A = 8'd1; B = 8'd2; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    repeat (10) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, lat);
      chk($sformatf("vec%0d_latency", i), lat, W);
      chk($sformatf("vec%0d_sum", i), Sum, vecs[i].e_sum);
      chk($sformatf("vec%0d_cout", i), Cout, vecs[i].e_cout);
      chk($sformatf("vec%0d_ovf", i), Overflow, vecs[i].e_ovf);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_one_cycle", i), done, 0);
    end

    // start while busy must be ignored
    @(negedge clk);
    A = 8'd10; B = 8'd20; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (c == 3) begin A = 8'd1; B = 8'd1; start = 1'b1; end
      if (c == 4) start = 1'b0;
    end
    chk("ignore_done_count", ndone, 1);
    chk("ignore_sum", Sum, 30);

    // back-to-back: start held during the done cycle
    run_op(8'd10, 8'd20, 1'b0, lat);
    chk("b2b_first_sum", Sum, 30);
    A = 8'd3; B = 8'd4; sub = 1'b0; start = 1'b1;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        start = 1'b0;
        chk("b2b_busy", busy, 1);
      end
      if (c == 5) chk("b2b_sum_held", Sum, 30);
      if (done) begin
        lat = c;
        break;
      end
    end
    chk("b2b_gap", lat, W + 1);
    chk("b2b_second_sum", Sum, 7);

    // reset in the middle of an operation
    @(negedge clk);
    A = 8'd50; B = 8'd60; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sum", Sum, 0);
    chk("midrst_cout", Cout, 0);
    chk("midrst_ovf", Overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);

    // randomized operations against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, m_sum, m_cout, m_ovf);
      run_op(ra, rb, rs, lat);
      chk($sformatf("rnd%0d_latency", i), lat, W);
      chk($sformatf("rnd%0d_sum a=%0d b=%0d sub=%0d", i, ra, rb, rs), Sum, m_sum);
      chk($sformatf("rnd%0d_cout", i), Cout, m_cout);
      chk($sformatf("rnd%0d_ovf", i), Overflow, m_ovf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
